// File: rtl/updn_sweep_ctrl_pkg.sv
// Shared definitions for the up/down sweep controller: state encoding,
// dwell timer width and parameter defaults.
package updn_ctrl_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_UP       = 3'd2,
        ST_DWELL_HI = 3'd3,
        ST_DOWN     = 3'd4,
        ST_DWELL_LO = 3'd5
    } state_t;

    // Wide enough for the largest legal dwell (255 cycles).
    localparam int DWELL_W = 8;

    localparam int DEF_WIDTH     = 5;
    localparam int DEF_SW_W      = 4;
    localparam int DEF_DWELL_CYC = 2;

endpackage

// File: rtl/updn_sweep_ctrl_if.sv
// Bundle of host command/status and counter datapath signals around the
// sweep controller. The controller is the slave; its environment is the master.
interface updn_sweep_ctrl_if #(
    parameter int WIDTH = updn_ctrl_pkg::DEF_WIDTH,
    parameter int SW_W  = updn_ctrl_pkg::DEF_SW_W
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] cfg_start;
    logic [WIDTH-1:0] cfg_lower;
    logic [WIDTH-1:0] cfg_upper;
    logic [SW_W-1:0]  cfg_sweeps;

    logic [WIDTH-1:0] cnt_val;
    logic             cnt_high;
    logic             cnt_low;
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_load;
    logic             cnt_up;
    logic             cnt_down;

    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [SW_W-1:0]  sweep_cnt;

    modport slave (
        input  start, abort, cfg_start, cfg_lower, cfg_upper, cfg_sweeps,
        input  cnt_val, cnt_high, cnt_low,
        output cnt_in, cnt_load, cnt_up, cnt_down,
        output busy, done, cfg_err, sweep_cnt
    );

    modport master (
        output start, abort, cfg_start, cfg_lower, cfg_upper, cfg_sweeps,
        output cnt_val, cnt_high, cnt_low,
        input  cnt_in, cnt_load, cnt_up, cnt_down,
        input  busy, done, cfg_err, sweep_cnt
    );
endinterface

// File: rtl/updn_sweep_ctrl_dwell_timer.sv
// Dwell down-counter: load_i arms it for DWELL_CYC cycles, expire_o marks
// the final cycle of the dwell.
module dwell_timer
    import updn_ctrl_pkg::*;
#(
    parameter int DWELL_CYC = DEF_DWELL_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic expire_o
);

    localparam logic [DWELL_W-1:0] RELOAD = DWELL_W'(DWELL_CYC - 1);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/updn_sweep_ctrl.sv
// Triangular sweep sequencer for an external up/down counter: load start,
// count to the upper limit, dwell, count to the lower limit, dwell, repeat.
module updn_sweep_ctrl
    import updn_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SW_W      = DEF_SW_W,
    parameter int DWELL_CYC = DEF_DWELL_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    updn_sweep_ctrl_if.slave sw_if
);

    function automatic logic [SW_W-1:0] sat_inc(input logic [SW_W-1:0] v);
        return (&v) ? v : v + SW_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] start_q, lower_q, upper_q;
    logic [SW_W-1:0]  sweeps_q;
    logic [SW_W-1:0]  sweep_cnt_q, sweep_cnt_d;
    logic             done_q, cfg_err_q;

    logic             cmd, cfg_ok, at_upper, at_lower;
    logic             dwell_load, dwell_expire;
    logic             sweep_end, last_sweep;
    logic [SW_W-1:0]  sweep_inc;
    logic             load_o, up_o, down_o;

    // A start is only a command in IDLE, and abort always takes priority.
    assign cmd        = (state_q == ST_IDLE) && sw_if.start && !sw_if.abort;
    assign cfg_ok     = (sw_if.cfg_lower <= sw_if.cfg_start) &&
                        (sw_if.cfg_start <= sw_if.cfg_upper);
    assign at_upper   = (sw_if.cnt_val == upper_q);
    assign at_lower   = (sw_if.cnt_val == lower_q);
    assign sweep_inc  = sat_inc(sweep_cnt_q);
    assign last_sweep = (sweeps_q != '0) && (sweep_inc == sweeps_q);
    assign sweep_end  = (state_q == ST_DWELL_LO) && dwell_expire && !sw_if.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (cmd && cfg_ok) state_d = ST_LOAD;
            ST_LOAD:     state_d = ST_UP;
            ST_UP:       if (at_upper) state_d = ST_DWELL_HI;
            ST_DWELL_HI: if (dwell_expire) state_d = ST_DOWN;
            ST_DOWN:     if (at_lower) state_d = ST_DWELL_LO;
            ST_DWELL_LO: if (dwell_expire) state_d = last_sweep ? ST_IDLE : ST_UP;
            default:     state_d = ST_IDLE;
        endcase
        if (sw_if.abort) begin
            state_d = ST_IDLE;
        end
    end

    // Enables are pure decode; the limit and rail checks keep the counter
    // from overshooting or wrapping even if a limit sits at a rail.
    always_comb begin
        load_o     = 1'b0;
        up_o       = 1'b0;
        down_o     = 1'b0;
        dwell_load = 1'b0;
        case (state_q)
            ST_LOAD: load_o = 1'b1;
            ST_UP: begin
                up_o       = !at_upper && !sw_if.cnt_high;
                dwell_load = at_upper;
            end
            ST_DOWN: begin
                down_o     = !at_lower && !sw_if.cnt_low;
                dwell_load = at_lower;
            end
            default: ;
        endcase
        if (sw_if.abort) begin
            load_o = 1'b0;
            up_o   = 1'b0;
            down_o = 1'b0;
        end
    end

    always_comb begin
        sweep_cnt_d = sweep_cnt_q;
        if (cmd && cfg_ok) begin
            sweep_cnt_d = '0;
        end else if (sweep_end) begin
            sweep_cnt_d = sweep_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= '0;
            lower_q     <= '0;
            upper_q     <= '0;
            sweeps_q    <= '0;
            sweep_cnt_q <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            done_q      <= sweep_end && last_sweep;
            cfg_err_q   <= cmd && !cfg_ok;
            sweep_cnt_q <= sweep_cnt_d;
            if (cmd) begin
                start_q  <= sw_if.cfg_start;
                lower_q  <= sw_if.cfg_lower;
                upper_q  <= sw_if.cfg_upper;
                sweeps_q <= sw_if.cfg_sweeps;
            end
        end
    end

    dwell_timer #(
        .DWELL_CYC (DWELL_CYC)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (dwell_load),
        .expire_o (dwell_expire)
    );

    assign sw_if.cnt_in    = start_q;
    assign sw_if.cnt_load  = load_o;
    assign sw_if.cnt_up    = up_o;
    assign sw_if.cnt_down  = down_o;
    assign sw_if.busy      = (state_q != ST_IDLE);
    assign sw_if.done      = done_q;
    assign sw_if.cfg_err   = cfg_err_q;
    assign sw_if.sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_updn_sweep_ctrl.sv
// Bench for updn_sweep_ctrl driving a behavioural 5-bit up/down counter and
// comparing every cycle against a sweep-profile model built from the limits.
module tb_updn_sweep_ctrl;

    localparam int WIDTH = 5;
    localparam int SW_W  = 4;
    localparam int DWELL = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    int exp_val[$];
    int exp_sw[$];

    always #5 clk = ~clk;

    updn_sweep_ctrl_if #(.WIDTH(WIDTH), .SW_W(SW_W)) sw_if ();

    updn_sweep_ctrl #(.WIDTH(WIDTH), .SW_W(SW_W), .DWELL_CYC(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_if (sw_if)
    );

    // External counter: load beats up beats down, free wrap if misdriven.
    logic [WIDTH-1:0] ctr_q = '0;
    always @(posedge clk) begin
        if (sw_if.cnt_load)      ctr_q <= sw_if.cnt_in;
        else if (sw_if.cnt_up)   ctr_q <= ctr_q + 1'b1;
        else if (sw_if.cnt_down) ctr_q <= ctr_q - 1'b1;
    end
    assign sw_if.cnt_val  = ctr_q;
    assign sw_if.cnt_high = &ctr_q;
    assign sw_if.cnt_low  = (ctr_q == '0);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int s, input int lo, input int hi, input int sw);
        sw_if.cfg_start  = WIDTH'(s);
        sw_if.cfg_lower  = WIDTH'(lo);
        sw_if.cfg_upper  = WIDTH'(hi);
        sw_if.cfg_sweeps = SW_W'(sw);
    endtask

    task automatic push_exp(input int v, input int k);
        exp_val.push_back(v);
        exp_sw.push_back(k > 15 ? 15 : k);
    endtask

    // Counter value seen in each busy cycle after LOAD, with completed-sweep count.
    task automatic build_model(input int s, input int lo, input int hi, input int nsw);
        exp_val.delete();
        exp_sw.delete();
        for (int k = 0; k < nsw; k++) begin
            for (int v = (k == 0 ? s : lo); v <= hi; v++) push_exp(v, k);
            repeat (DWELL) push_exp(hi, k);
            for (int v = hi; v >= lo; v--) push_exp(v, k);
            repeat (DWELL) push_exp(lo, k);
        end
    endtask

    task automatic run_sweep(input string name, input int s, input int lo, input int hi, input int sw);
        int nsw;
        bit bad;
        nsw = (sw == 0) ? 3 : sw;
        build_model(s, lo, hi, nsw);
        set_cfg(s, lo, hi, sw);
        sw_if.start = 1'b1;
        tick();
        sw_if.start = 1'b0;
        n_tests++;
        if (sw_if.cnt_load !== 1'b1 || sw_if.busy !== 1'b1 || sw_if.cnt_in !== WIDTH'(s) ||
            sw_if.sweep_cnt !== '0 || sw_if.cnt_up !== 1'b0 || sw_if.cnt_down !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_load: load=%b busy=%b cnt_in=%0d sweep_cnt=%0d up=%b down=%b, required 1 1 %0d 0 0 0",
                     name, sw_if.cnt_load, sw_if.busy, sw_if.cnt_in, sw_if.sweep_cnt,
                     sw_if.cnt_up, sw_if.cnt_down, s);
        end
        bad = 1'b0;
        for (int i = 0; i < exp_val.size() && !bad; i++) begin
            // Busy-time noise on the host side must not disturb the run.
            sw_if.start = ($urandom_range(0, 4) == 0);
            set_cfg($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 15));
            tick();
            n_tests++;
            if (sw_if.cnt_val !== WIDTH'(exp_val[i]) || sw_if.sweep_cnt !== SW_W'(exp_sw[i]) ||
                sw_if.busy !== 1'b1 || sw_if.done !== 1'b0 || sw_if.cfg_err !== 1'b0 ||
                $countones({sw_if.cnt_load, sw_if.cnt_up, sw_if.cnt_down}) > 1) begin
                n_fail++;
                bad = 1'b1;
                $display("FAIL %s_cycle%0d: cnt_val=%0d sweep_cnt=%0d busy=%b done=%b cfg_err=%b ld/up/dn=%b%b%b, required cnt_val=%0d sweep_cnt=%0d busy=1 done=0 cfg_err=0 one enable max",
                         name, i, sw_if.cnt_val, sw_if.sweep_cnt, sw_if.busy, sw_if.done, sw_if.cfg_err,
                         sw_if.cnt_load, sw_if.cnt_up, sw_if.cnt_down, exp_val[i], exp_sw[i]);
            end
        end
        sw_if.start = 1'b0;
        if (bad) begin
            sw_if.abort = 1'b1;
            tick();
            sw_if.abort = 1'b0;
            tick();
        end else if (sw == 0) begin
            tick();
            n_tests++;
            if (sw_if.cnt_val !== WIDTH'(lo) || sw_if.busy !== 1'b1 || sw_if.sweep_cnt !== SW_W'(nsw)) begin
                n_fail++;
                $display("FAIL %s_wrap: cnt_val=%0d busy=%b sweep_cnt=%0d, required %0d 1 %0d",
                         name, sw_if.cnt_val, sw_if.busy, sw_if.sweep_cnt, lo, nsw);
            end
            sw_if.abort = 1'b1;
            #1;
            n_tests++;
            if ({sw_if.cnt_load, sw_if.cnt_up, sw_if.cnt_down} !== 3'b000) begin
                n_fail++;
                $display("FAIL %s_abort_enables: ld/up/dn=%b%b%b, required 000",
                         name, sw_if.cnt_load, sw_if.cnt_up, sw_if.cnt_down);
            end
            tick();
            sw_if.abort = 1'b0;
            n_tests++;
            if (sw_if.busy !== 1'b0 || sw_if.done !== 1'b0 || sw_if.sweep_cnt !== SW_W'(nsw) ||
                sw_if.cnt_val !== WIDTH'(lo)) begin
                n_fail++;
                $display("FAIL %s_aborted: busy=%b done=%b sweep_cnt=%0d cnt_val=%0d, required 0 0 %0d %0d",
                         name, sw_if.busy, sw_if.done, sw_if.sweep_cnt, sw_if.cnt_val, nsw, lo);
            end
        end else begin
            tick();
            n_tests++;
            if (sw_if.done !== 1'b1 || sw_if.busy !== 1'b0 || sw_if.sweep_cnt !== SW_W'(sw) ||
                sw_if.cnt_val !== WIDTH'(lo)) begin
                n_fail++;
                $display("FAIL %s_done: done=%b busy=%b sweep_cnt=%0d cnt_val=%0d, required 1 0 %0d %0d",
                         name, sw_if.done, sw_if.busy, sw_if.sweep_cnt, sw_if.cnt_val, sw, lo);
            end
            tick();
            n_tests++;
            if (sw_if.done !== 1'b0 || sw_if.busy !== 1'b0 || sw_if.sweep_cnt !== SW_W'(sw)) begin
                n_fail++;
                $display("FAIL %s_after_done: done=%b busy=%b sweep_cnt=%0d, required 0 0 %0d",
                         name, sw_if.done, sw_if.busy, sw_if.sweep_cnt, sw);
            end
        end
    endtask

    task automatic test_reset();
        sw_if.start = 1'b0;
        sw_if.abort = 1'b0;
        set_cfg(0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) tick();
        n_tests++;
        if ({sw_if.busy, sw_if.done, sw_if.cfg_err, sw_if.cnt_load, sw_if.cnt_up, sw_if.cnt_down} !== 6'b0 ||
            sw_if.sweep_cnt !== '0 || sw_if.cnt_in !== '0) begin
            n_fail++;
            $display("FAIL reset: busy/done/err/ld/up/dn=%b%b%b%b%b%b sweep_cnt=%0d cnt_in=%0d, required all 0",
                     sw_if.busy, sw_if.done, sw_if.cfg_err, sw_if.cnt_load, sw_if.cnt_up, sw_if.cnt_down,
                     sw_if.sweep_cnt, sw_if.cnt_in);
        end
        #3 rst_n = 1'b1;
        tick();
        n_tests++;
        if (sw_if.busy !== 1'b0 || sw_if.cnt_load !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b load=%b, required 0 0", sw_if.busy, sw_if.cnt_load);
        end
    endtask

    task automatic test_directed();
        run_sweep("basic", 3, 2, 6, 1);
        run_sweep("full_range", 31, 0, 31, 2);
        run_sweep("degenerate", 5, 5, 5, 2);
        run_sweep("start_at_lower", 4, 4, 9, 1);
    endtask

    task automatic test_cfg_err();
        int s, lo, hi;
        for (int n = 0; n < 5; n++) begin
            if (n == 0) begin
                s = 7; lo = 10; hi = 5;
            end else if (n % 2 == 1) begin
                lo = $urandom_range(1, 31); hi = $urandom_range(lo, 31); s = $urandom_range(0, lo - 1);
            end else begin
                lo = $urandom_range(0, 30); hi = $urandom_range(lo, 30); s = $urandom_range(hi + 1, 31);
            end
            set_cfg(s, lo, hi, 1);
            sw_if.start = 1'b1;
            tick();
            sw_if.start = 1'b0;
            n_tests++;
            if (sw_if.cfg_err !== 1'b1 || sw_if.busy !== 1'b0 || sw_if.cnt_load !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_err_pulse%0d (s=%0d lo=%0d hi=%0d): cfg_err=%b busy=%b load=%b, required 1 0 0",
                         n, s, lo, hi, sw_if.cfg_err, sw_if.busy, sw_if.cnt_load);
            end
            tick();
            n_tests++;
            if (sw_if.cfg_err !== 1'b0 || sw_if.busy !== 1'b0 || sw_if.cnt_load !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_err_clear%0d: cfg_err=%b busy=%b load=%b, required 0 0 0",
                         n, sw_if.cfg_err, sw_if.busy, sw_if.cnt_load);
            end
        end
    endtask

    task automatic test_abort_vs_start();
        set_cfg(3, 2, 6, 1);
        sw_if.start = 1'b1;
        sw_if.abort = 1'b1;
        tick();
        sw_if.start = 1'b0;
        sw_if.abort = 1'b0;
        n_tests++;
        if (sw_if.busy !== 1'b0 || sw_if.cnt_load !== 1'b0 || sw_if.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_beats_start: busy=%b load=%b cfg_err=%b, required 0 0 0",
                     sw_if.busy, sw_if.cnt_load, sw_if.cfg_err);
        end
    endtask

    // Abort on the second pass through value 4 while counting down.
    task automatic test_abort_down();
        int hits, prev_sw;
        hits = 0;
        set_cfg(6, 1, 7, 2);
        sw_if.start = 1'b1;
        tick();
        sw_if.start = 1'b0;
        for (int i = 0; i < 300 && hits < 2; i++) begin
            tick();
            if (sw_if.cnt_down === 1'b1 && sw_if.cnt_val === WIDTH'(4)) hits++;
        end
        n_tests++;
        if (hits != 2) begin
            n_fail++;
            $display("FAIL abort_down_reach: saw %0d down-at-4 cycles, required 2", hits);
        end else begin
            prev_sw = 1;
            n_tests++;
            if (sw_if.sweep_cnt !== SW_W'(prev_sw)) begin
                n_fail++;
                $display("FAIL abort_down_precount: sweep_cnt=%0d, required %0d", sw_if.sweep_cnt, prev_sw);
            end
            sw_if.abort = 1'b1;
            #1;
            n_tests++;
            if ({sw_if.cnt_load, sw_if.cnt_up, sw_if.cnt_down} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_down_enables: ld/up/dn=%b%b%b, required 000",
                         sw_if.cnt_load, sw_if.cnt_up, sw_if.cnt_down);
            end
            tick();
            sw_if.abort = 1'b0;
            for (int j = 0; j < 3; j++) begin
                n_tests++;
                if (sw_if.busy !== 1'b0 || sw_if.done !== 1'b0 || sw_if.cnt_val !== WIDTH'(4) ||
                    sw_if.sweep_cnt !== SW_W'(prev_sw)) begin
                    n_fail++;
                    $display("FAIL abort_down_hold%0d: busy=%b done=%b cnt_val=%0d sweep_cnt=%0d, required 0 0 4 %0d",
                             j, sw_if.busy, sw_if.done, sw_if.cnt_val, sw_if.sweep_cnt, prev_sw);
                end
                tick();
            end
        end
        sw_if.abort = 1'b1;
        tick();
        sw_if.abort = 1'b0;
    endtask

    task automatic test_continuous();
        run_sweep("continuous", 2, 1, 3, 0);
    endtask

    // Reset asserted between clock edges in the first dwell-at-upper cycle.
    task automatic test_reset_mid_run();
        bit found;
        found = 1'b0;
        set_cfg(2, 2, 9, 1);
        sw_if.start = 1'b1;
        tick();
        sw_if.start = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (sw_if.busy === 1'b1 && sw_if.cnt_val === WIDTH'(9) &&
                {sw_if.cnt_load, sw_if.cnt_up, sw_if.cnt_down} === 3'b000) found = 1'b1;
        end
        tick();
        n_tests++;
        if (!found || sw_if.busy !== 1'b1 || sw_if.cnt_val !== WIDTH'(9) ||
            {sw_if.cnt_load, sw_if.cnt_up, sw_if.cnt_down} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_reach: found=%b busy=%b cnt_val=%0d, required 1 1 9 in dwell",
                     found, sw_if.busy, sw_if.cnt_val);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sw_if.busy, sw_if.done, sw_if.cfg_err, sw_if.cnt_load, sw_if.cnt_up, sw_if.cnt_down} !== 6'b0 ||
            sw_if.sweep_cnt !== '0 || sw_if.cnt_in !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: busy/done/err/ld/up/dn=%b%b%b%b%b%b sweep_cnt=%0d cnt_in=%0d, required all 0",
                     sw_if.busy, sw_if.done, sw_if.cfg_err, sw_if.cnt_load, sw_if.cnt_up, sw_if.cnt_down,
                     sw_if.sweep_cnt, sw_if.cnt_in);
        end
        tick();
        #3 rst_n = 1'b1;
        tick();
        run_sweep("after_reset", 5, 3, 8, 1);
    endtask

    task automatic test_random();
        int lo, hi, s, sw;
        for (int n = 0; n < 6; n++) begin
            lo = $urandom_range(0, 31);
            hi = $urandom_range(lo, 31);
            s  = $urandom_range(lo, hi);
            sw = $urandom_range(1, 2);
            run_sweep($sformatf("random%0d", n), s, lo, hi, sw);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_cfg_err();
        test_abort_vs_start();
        test_abort_down();
        test_continuous();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
